// File: rtl/usr.sv
// usr -- parameterised universal shift register.
//
// One WIDTH-bit register. A 2-bit mode input selects the operation taken on
// each rising clock edge: hold, serial shift right, serial shift left, or
// parallel load.
//
// Optional feature macro: USR_SERIAL_OUT_EN
//   defined     -> the ports so_right (= Q[0]) and so_left (= Q[WIDTH-1]) exist.
//   not defined -> those ports are absent. Everything else is unchanged.
//
// Reset is asynchronous and active-low. Deassertion must be synchronised to
// clk outside this block. The first rising edge after release performs the
// operation selected by S.
module usr #(
    parameter int WIDTH = 4   // legal range 2..64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       S,
    input  logic [WIDTH-1:0] D,
    input  logic             SR,
    input  logic             SL,
    output logic [WIDTH-1:0] Q
`ifdef USR_SERIAL_OUT_EN
    ,
    output logic             so_right,
    output logic             so_left
`endif
);

    // Mode encodings carried on S.
    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;

    // Select the next register value from the mode. The case items are
    // matched exactly, so an S carrying X/Z in simulation matches none of
    // them and falls through to the default, which holds the register.
    always_comb begin
        q_next = q_reg;
        case (S)
            MODE_HOLD:  q_next = q_reg;
            MODE_RIGHT: q_next = {SR, q_reg[WIDTH-1:1]};
            MODE_LEFT:  q_next = {q_reg[WIDTH-2:0], SL};
            MODE_LOAD:  q_next = D;
            default:    q_next = q_reg;
        endcase
    end

    // The only state: the register itself. Reset clears it at once and
    // masks clock edges for as long as it is held low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign Q = q_reg;

`ifdef USR_SERIAL_OUT_EN
    // The serial outputs are taps on the register's end bits, so they come
    // straight from flops and clear together with the register.
    assign so_right = q_reg[0];
    assign so_left  = q_reg[WIDTH-1];
`endif

endmodule

// File: tb/tb_usr.sv
// tb_usr -- self-checking bench for usr.
// Two instances (WIDTH=4 and WIDTH=8) share S, SR, SL and reset. Each has its
// own D. A behavioural model computes the expected register contents for both.
module tb_usr;

    logic       clk;
    logic       reset;
    logic [1:0] S;
    logic [3:0] D4;
    logic [7:0] D8;
    logic       SR;
    logic       SL;
    logic [3:0] Q4;
    logic [7:0] Q8;
`ifdef USR_SERIAL_OUT_EN
    logic       so_right4, so_left4, so_right8, so_left8;
`endif

    int total = 0;
    int bad   = 0;

    // expected register contents
    logic [3:0] m4;
    logic [7:0] m8;

    usr #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .S(S), .D(D4), .SR(SR), .SL(SL), .Q(Q4)
`ifdef USR_SERIAL_OUT_EN
        , .so_right(so_right4), .so_left(so_left4)
`endif
    );

    usr #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .S(S), .D(D8), .SR(SR), .SL(SL), .Q(Q8)
`ifdef USR_SERIAL_OUT_EN
        , .so_right(so_right8), .so_left(so_left8)
`endif
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        reset = 1'b0;
        S = 2'b00; D4 = '0; D8 = '0; SR = 1'b0; SL = 1'b0;
    end

    // Reference: what a universal shift register of width w does to q.
    function automatic logic [63:0] ref_next(input int w, input logic [63:0] q,
                                             input logic [1:0] s, input logic [63:0] d,
                                             input logic sr, input logic sl);
        logic [63:0] mask;
        mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        if (s == 2'd1)      return ((q >> 1) | (64'(sr) << (w - 1))) & mask;
        else if (s == 2'd2) return ((q << 1) | 64'(sl)) & mask;
        else if (s == 2'd3) return d & mask;
        else                return q & mask;
    endfunction

    // driver: present inputs, take one edge, advance the model
    task automatic drive(input logic [1:0] s, input logic [3:0] d4, input logic [7:0] d8,
                         input logic sr, input logic sl);
        S = s; D4 = d4; D8 = d8; SR = sr; SL = sl;
        @(posedge clk);
        #1;
        if (reset) begin
            m4 = 4'(ref_next(4, 64'(m4), s, 64'(d4), sr, sl));
            m8 = 8'(ref_next(8, 64'(m8), s, 64'(d8), sr, sl));
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (Q4 !== 4'b0000 || Q8 !== 8'h00) begin
            bad++;
            $display("FAIL reset_initial Q4=%b Q8=%h want 0", Q4, Q8);
        end
        m4 = '0; m8 = '0;
        release_reset();
        drive(2'b11, 4'b1010, 8'hA5, 1'b0, 1'b0);
        total++;
        if (Q4 !== 4'b1010) begin
            bad++;
            $display("FAIL reset_preload Q4=%b want 1010", Q4);
        end
        // assert reset mid-cycle while a load is pending
        S = 2'b11; D4 = 4'b1111; D8 = 8'hFF;
        #2 reset = 1'b0;
        #1;
        m4 = '0; m8 = '0;
        total++;
        if (Q4 !== 4'b0000 || Q8 !== 8'h00) begin
            bad++;
            $display("FAIL reset_async Q4=%b Q8=%h want 0", Q4, Q8);
        end
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, (i % 2 == 0) ? 4'b1111 : 4'b0101, 8'hFF, 1'b1, 1'b1);
            total++;
            if (Q4 !== 4'b0000 || Q8 !== 8'h00) begin
                bad++;
                $display("FAIL reset_held%0d Q4=%b Q8=%h want 0", i, Q4, Q8);
            end
        end
        S = 2'b00;
        release_reset();
    endtask

    task automatic test_hold();
        for (int i = 0; i < 3; i++) begin
            drive(2'b00, 4'b1010, 8'hAA, 1'b1, 1'b1);
            total++;
            if (Q4 !== 4'b0000 || Q4 !== m4 || Q8 !== m8) begin
                bad++;
                $display("FAIL hold%0d Q4=%b Q8=%h want %b %h", i, Q4, Q8, m4, m8);
            end
        end
    endtask

    task automatic test_shift_right();
        logic [3:0] plan [5];
        plan[0] = 4'b1000; plan[1] = 4'b1100; plan[2] = 4'b1110;
        plan[3] = 4'b1111; plan[4] = 4'b0111;
        for (int i = 0; i < 5; i++) begin
            drive(2'b01, 4'b0101, 8'h55, (i < 4) ? 1'b1 : 1'b0, 1'b1);
            total++;
            if (Q4 !== plan[i] || Q4 !== m4 || Q8 !== m8) begin
                bad++;
                $display("FAIL shift_right%0d Q4=%b Q8=%h want %b %h", i, Q4, Q8, plan[i], m8);
            end
        end
    endtask

    task automatic test_shift_left();
        logic [3:0] plan [4];
        plan[0] = 4'b1110; plan[1] = 4'b1100; plan[2] = 4'b1000; plan[3] = 4'b0000;
        drive(2'b11, 4'b1111, 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(2'b10, 4'b1111, 8'h3C, 1'b1, 1'b0);
            total++;
            if (Q4 !== plan[i] || Q4 !== m4 || Q8 !== m8) begin
                bad++;
                $display("FAIL shift_left%0d Q4=%b Q8=%h want %b %h", i, Q4, Q8, plan[i], m8);
            end
        end
    endtask

    task automatic test_load_priority();
        drive(2'b11, 4'b1010, 8'h5A, 1'b0, 1'b0);
        total++;
        if (Q4 !== 4'b1010 || Q8 !== 8'h5A) begin
            bad++;
            $display("FAIL load Q4=%b Q8=%h want 1010 5a", Q4, Q8);
        end
        drive(2'b00, 4'b0101, 8'hC3, 1'b1, 1'b1);
        total++;
        if (Q4 !== 4'b1010 || Q8 !== 8'h5A) begin
            bad++;
            $display("FAIL load_hold Q4=%b Q8=%h want 1010 5a", Q4, Q8);
        end
        #2 reset = 1'b0;
        #1;
        m4 = '0; m8 = '0;
        total++;
        if (Q4 !== 4'b0000 || Q8 !== 8'h00) begin
            bad++;
            $display("FAIL load_reset Q4=%b Q8=%h want 0", Q4, Q8);
        end
        // first edge after release performs the selected operation
        S = 2'b11; D4 = 4'b0110; D8 = 8'h96;
        release_reset();
        drive(2'b11, 4'b0110, 8'h96, 1'b0, 1'b0);
        total++;
        if (Q4 !== 4'b0110 || Q8 !== 8'h96) begin
            bad++;
            $display("FAIL release_load Q4=%b Q8=%h want 0110 96", Q4, Q8);
        end
    endtask

    task automatic test_x_mode();
        drive(2'bxx, 4'b1111, 8'hFF, 1'b1, 1'b1);
        total++;
        if (Q4 !== m4 || Q8 !== m8) begin
            bad++;
            $display("FAIL x_mode Q4=%b Q8=%h want %b %h", Q4, Q8, m4, m8);
        end
        S = 2'b00;
    endtask

`ifdef USR_SERIAL_OUT_EN
    task automatic test_serial_out();
        drive(2'b11, 4'b1001, 8'h81, 1'b0, 1'b0);
        total++;
        if (Q8 !== 8'h81 || so_right8 !== 1'b1 || so_left8 !== 1'b1) begin
            bad++;
            $display("FAIL serial_load Q8=%h sr=%b sl=%b want 81 1 1", Q8, so_right8, so_left8);
        end
        drive(2'b01, 4'b0000, 8'h00, 1'b0, 1'b0);
        total++;
        if (Q8 !== 8'h40 || so_right8 !== 1'b0 || so_left8 !== 1'b0) begin
            bad++;
            $display("FAIL serial_shift Q8=%h sr=%b sl=%b want 40 0 0", Q8, so_right8, so_left8);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                #2 reset = 1'b0;
                #1;
                m4 = '0; m8 = '0;
                total++;
                if (Q4 !== 4'b0000 || Q8 !== 8'h00) begin
                    bad++;
                    $display("FAIL rand_reset%0d Q4=%b Q8=%h want 0", i, Q4, Q8);
                end
                release_reset();
            end
            drive(2'($urandom_range(0, 3)), 4'($urandom), 8'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            total++;
            if (Q4 !== m4 || Q8 !== m8) begin
                bad++;
                $display("FAIL rand%0d Q4=%b Q8=%h want %b %h", i, Q4, Q8, m4, m8);
            end
`ifdef USR_SERIAL_OUT_EN
            total++;
            if (so_right4 !== m4[0] || so_left4 !== m4[3] ||
                so_right8 !== m8[0] || so_left8 !== m8[7]) begin
                bad++;
                $display("FAIL rand_serial%0d got %b%b%b%b", i, so_right4, so_left4, so_right8, so_left8);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_hold();
        test_shift_right();
        test_shift_left();
        test_load_priority();
        test_x_mode();
`ifdef USR_SERIAL_OUT_EN
        test_serial_out();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
